// File: rtl/opbuf_pkg.sv
// Shared types and defaults for the operand buffer.
// Optional feature macro used by operand_buffer: OPBUF_ZERO_PAD_EN.
package opbuf_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESULT = 2'd3
  } opbuf_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  // The top address of a bank is never written, so a vector holds at most 2^aw-1 words.
  function automatic int max_len(input int aw);
    return (1 << aw) - 1;
  endfunction

endpackage

// File: rtl/opbuf_bank.sv
// One operand bank: single write port, one registered read port.
// The read register can be forced to zero by the parent (used for zero padding).
module opbuf_bank
  import opbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic                  i_rzero,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage has no reset so its contents persist across reset and across vectors.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_rzero) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/operand_buffer.sv
// Double-bank operand buffer feeding a compute engine and holding its result.
// Define OPBUF_ZERO_PAD_EN to return zero for reads beyond the valid vector length.
module operand_buffer
  import opbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  start,
  output logic [ADDR_WIDTH-1:0] vec_length,
  input  logic [ADDR_WIDTH-1:0] patch_addr,
  input  logic [ADDR_WIDTH-1:0] filter_addr,
  output logic [DATA_WIDTH-1:0] patch_data,
  output logic [DATA_WIDTH-1:0] filter_data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  len_err
);

  localparam logic [ADDR_WIDTH-1:0] LP_MAX = ADDR_WIDTH'(max_len(ADDR_WIDTH));

  opbuf_state_e          r_state;
  opbuf_state_e          w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt [2];
  logic [1:0]            r_cmp;
  logic [ADDR_WIDTH-1:0] r_vec_len;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_len_err;

  logic                  w_acc;
  logic [1:0]            w_we;
  logic                  w_clr;
  logic                  w_len_err_set;
  logic                  w_launch;
  logic                  w_capture;
  logic                  w_release;
  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];
  logic [1:0]            w_rzero;

  assign wr_ready = (r_state == ST_LOAD) && !r_cmp[wr_sel];
  assign w_acc    = wr_valid && wr_ready;
  assign w_we[0]  = w_acc && !wr_sel;
  assign w_we[1]  = w_acc && wr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_clr         = 1'b0;
    w_len_err_set = 1'b0;
    w_launch      = 1'b0;
    w_capture     = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (r_cmp == 2'b11) begin
          if (r_cnt[0] == r_cnt[1]) begin
            w_launch     = 1'b1;
            w_state_next = ST_LAUNCH;
          end else begin
            w_len_err_set = 1'b1;
            w_clr         = 1'b1;
          end
        end
      end
      ST_LAUNCH: w_state_next = ST_BUSY;
      ST_BUSY: begin
        if (done) begin
          w_capture    = 1'b1;
          w_state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (r_res_valid && res_ready) begin
          w_release    = 1'b1;
          w_clr        = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  // A bank closes on wr_last or when the beat just written fills its last usable slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      r_cmp    <= '0;
    end else if (w_clr) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      r_cmp    <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_we[b]) begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
          if (wr_last || ((r_cnt[b] + 1'b1) == LP_MAX)) begin
            r_cmp[b] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_len   <= '0;
      r_len_err   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_len_err <= w_len_err_set;
      if (w_launch) begin
        r_vec_len <= r_cnt[0];
      end
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= result;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign w_raddr[0] = patch_addr;
  assign w_raddr[1] = filter_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
`ifdef OPBUF_ZERO_PAD_EN
      // While loading, the bank's own fill level bounds valid reads.
      logic [ADDR_WIDTH-1:0] w_limit;
      assign w_limit      = (r_state == ST_LOAD) ? r_cnt[gi] : r_vec_len;
      assign w_rzero[gi]  = (w_raddr[gi] >= w_limit);
`else
      assign w_rzero[gi]  = 1'b0;
`endif
      opbuf_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we[gi]),
        .i_waddr (r_cnt[gi]),
        .i_wdata (wr_data),
        .i_raddr (w_raddr[gi]),
        .i_rzero (w_rzero[gi]),
        .o_rdata (w_rdata[gi])
      );
    end
  endgenerate

  assign patch_data  = w_rdata[0];
  assign filter_data = w_rdata[1];
  assign start       = (r_state == ST_LAUNCH);
  assign vec_length  = r_vec_len;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign len_err     = r_len_err;

endmodule
